score_tracker_multi: RTL and testbench
======================================

Name: score_tracker_multi

Overview:
Parametrised multi-player score tracker. Accepts one score submission per ScoreReq handshake and keeps a per-player record (best score or cumulative total) in an internal synchronous-read score memory with configurable read latency. Also keeps the global high score and its holder ID. Reports personal and global wins per submission. Sits between game/score logic and the display/announcement logic.

Parameters:
NUM_PLAYERS, 4, number of tracked players (2..16)
ID_W, 2, PlayerID width; must satisfy 2**ID_W >= NUM_PLAYERS
SCORE_W, 5, score width (unsigned)
READ_LAT, 2, score memory read latency in cycles (1..4)
MODE, 0, 0 = store best score; 1 = store saturating cumulative total

Ports:
Clk  in  1  clock; all logic on the rising edge
Rst  in  1  synchronous reset, active-high
ScoreReq  in  1  submission request level; held high until Done is seen
PlayerID  in  ID_W  submitting player; sampled on accept
Score  in  SCORE_W  submitted score; sampled on accept
ClearReq  in  1  clears all records; honoured only in IDLE
Busy  out  1  high from accept to the end of DONE, and throughout INIT
Done  out  1  one-cycle pulse; results are valid in this cycle
PersonalWin  out  1  the player's record increased
GlobalWinner  out  1  the submission set a new global high
Error  out  1  PlayerID >= NUM_PLAYERS; no update performed
PlayerRecord  out  SCORE_W  the player's stored value after the update
HighScore  out  SCORE_W  current global high score
HighID  out  ID_W  current global high holder

Behaviour:
- Reset (Rst=1 at an edge): all outputs 0, global registers 0, go to INIT. Rst overrides any in-flight operation. A partial write is not completed. Memory contents are undefined until INIT finishes.
- INIT: writes 0 to entries 0..NUM_PLAYERS-1, one per cycle, for NUM_PLAYERS cycles. Clears HighScore and HighID. Busy=1. Then goes to IDLE.
- IDLE: Busy=0.
  - If ClearReq=1, go to INIT. ClearReq has priority over ScoreReq in the same cycle.
  - Otherwise, if ScoreReq=1, accept: latch PlayerID and Score, clear PersonalWin, GlobalWinner and Error, set Busy=1.
  - If the latched ID >= NUM_PLAYERS, set Error=1 and go straight to DONE.
  - Otherwise go to READ.
- READ: present the latched ID as the read address and hold it for READ_LAT cycles. Then go to CMP.
- CMP: capture the memory output as old.
  - MODE0: new = Score.
  - MODE1: new = min(old + Score, 2**SCORE_W - 1), computed with a SCORE_W+1-bit sum.
  - If new > old (strict): PersonalWin=1 and issue the write. Go to WRITE.
- WRITE: write strobe de-asserted. PlayerRecord = max(old, new). Go to GCMP.
- GCMP: if new > HighScore (strict), then HighScore=new, HighID=ID, GlobalWinner=1. On a tie the earlier holder is kept. Go to DONE.
- DONE: Done=1 for exactly one cycle. Go to WAITREL.
- WAITREL: Busy=0. Stay while ScoreReq=1; go to IDLE when ScoreReq=0. No double-counting on a held request.
- Latency: the accept edge is cycle 0. Done is high in cycle READ_LAT+4 for a valid ID, and in cycle 1 for an error.
- Result outputs (PersonalWin, GlobalWinner, Error, PlayerRecord) hold until the next accept.
- HighScore and HighID are always live.
- ClearReq outside IDLE is ignored and is not queued.
- Only one memory write per submission. The read and write address is always the latched ID.

Test Plan:
1. Rst high for 2 cycles, then low → Busy=1 for NUM_PLAYERS cycles. All outputs 0. Then IDLE with Busy=0.
2. MODE0, defaults: player 2 submits 9 → Done in cycle 6, PersonalWin=1, GlobalWinner=1, HighScore=9, HighID=2. Player 2 submits 7 → PersonalWin=0, GlobalWinner=0, PlayerRecord=9.
3. Tie: player 1 submits 9 after test 2 → PersonalWin=1, GlobalWinner=0, HighID stays 2.
4. MODE1: player 0 submits 20, then 20 → PlayerRecord=20 then 31 (saturated), PersonalWin=1 both times. A third submission of 5 gives PersonalWin=0.
5. NUM_PLAYERS=3, PlayerID=3 → Error=1, Done in cycle 1, no memory change. A read-back of player 0 is unchanged.
6. ScoreReq held 20 cycles → exactly one Done. ClearReq together with ScoreReq in IDLE → INIT runs and HighScore=0. Rst asserted during READ → outputs 0 and INIT restarts.

Source files
------------

// File: rtl/score_tracker_multi.sv
// Multi-player score tracker: per-player best or cumulative record kept in a
// synchronous-read memory, plus a live global high score and its holder.
module score_tracker_multi #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned SCORE_W     = 5,
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned MODE        = 0
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               ScoreReq,
  input  logic [ID_W-1:0]    PlayerID,
  input  logic [SCORE_W-1:0] Score,
  input  logic               ClearReq,
  output logic               Busy,
  output logic               Done,
  output logic               PersonalWin,
  output logic               GlobalWinner,
  output logic               Error,
  output logic [SCORE_W-1:0] PlayerRecord,
  output logic [SCORE_W-1:0] HighScore,
  output logic [ID_W-1:0]    HighID
);

  localparam int unsigned MEM_DEPTH = 1 << ID_W;
  localparam int unsigned LAT_W     = 3;
  localparam int unsigned IDX_W     = ID_W + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // ST_RST is the cycle(s) Rst is held; it lets all NUM_PLAYERS INIT writes
  // follow reset release with Busy visible for each of them.
  typedef enum logic [3:0] {
    ST_RST,
    ST_INIT,
    ST_IDLE,
    ST_CHK,
    ST_READ,
    ST_CMP,
    ST_WRITE,
    ST_GCMP,
    ST_DONE,
    ST_WAITREL
  } state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]    init_cnt_q, init_cnt_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] old_q, old_d;
  logic [SCORE_W-1:0] new_q, new_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pwin_q, pwin_d;
  logic               gwin_q, gwin_d;
  logic               err_q, err_d;
  logic [SCORE_W-1:0] rec_q, rec_d;
  logic [SCORE_W-1:0] hs_q, hs_d;
  logic [ID_W-1:0]    hid_q, hid_d;

  logic               we_q, we_d;
  logic [ID_W-1:0]    waddr_q, waddr_d;
  logic [SCORE_W-1:0] wdata_q, wdata_d;

  logic [SCORE_W-1:0] mem [MEM_DEPTH];
  logic [SCORE_W-1:0] rd_pipe_q [READ_LAT];
  logic [SCORE_W-1:0] mem_rdata_c;
  logic [SCORE_W:0]   sum_c;
  logic [SCORE_W-1:0] cand_c;
  logic               id_bad_c;

  // Candidate record from the memory output and the latched score
  always_comb begin
    mem_rdata_c = rd_pipe_q[READ_LAT-1];
    sum_c       = {1'b0, mem_rdata_c} + {1'b0, score_q};
    if (MODE == 1) begin
      cand_c = sum_c[SCORE_W] ? SCORE_MAX : sum_c[SCORE_W-1:0];
    end else begin
      cand_c = score_q;
    end
    id_bad_c = {1'b0, id_q} >= IDX_W'(NUM_PLAYERS);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    id_d       = id_q;
    score_d    = score_q;
    old_d      = old_q;
    new_d      = new_q;
    pwin_d     = pwin_q;
    gwin_d     = gwin_q;
    err_d      = err_q;
    rec_d      = rec_q;
    hs_d       = hs_q;
    hid_d      = hid_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      ST_RST: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
      ST_INIT: begin
        we_d       = 1'b1;
        waddr_d    = init_cnt_q;
        wdata_d    = '0;
        hs_d       = '0;
        hid_d      = '0;
        init_cnt_d = init_cnt_q + ID_W'(1);
        if (init_cnt_q == ID_W'(NUM_PLAYERS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ClearReq) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end else if (ScoreReq) begin
          id_d    = PlayerID;
          score_d = Score;
          pwin_d  = 1'b0;
          gwin_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (id_bad_c) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          lat_cnt_d = '0;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        lat_cnt_d = lat_cnt_q + LAT_W'(1);
        if (lat_cnt_q == LAT_W'(READ_LAT - 1)) begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        old_d = mem_rdata_c;
        new_d = cand_c;
        if (cand_c > mem_rdata_c) begin
          pwin_d  = 1'b1;
          we_d    = 1'b1;
          waddr_d = id_q;
          wdata_d = cand_c;
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        rec_d   = (new_q > old_q) ? new_q : old_q;
        state_d = ST_GCMP;
      end
      ST_GCMP: begin
        // Strict compare: on a tie the earlier holder keeps the title
        if (new_q > hs_q) begin
          hs_d   = new_q;
          hid_d  = id_q;
          gwin_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_WAITREL;
      end
      ST_WAITREL: begin
        if (!ScoreReq) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase

    busy_d = (state_d inside {ST_INIT, ST_CHK, ST_READ, ST_CMP,
                              ST_WRITE, ST_GCMP, ST_DONE});
    done_d = (state_d == ST_DONE);
  end

  // State and control registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_RST;
      init_cnt_q <= '0;
      lat_cnt_q  <= '0;
      id_q       <= '0;
      score_q    <= '0;
      old_q      <= '0;
      new_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pwin_q     <= 1'b0;
      gwin_q     <= 1'b0;
      err_q      <= 1'b0;
      rec_q      <= '0;
      hs_q       <= '0;
      hid_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      id_q       <= id_d;
      score_q    <= score_d;
      old_q      <= old_d;
      new_q      <= new_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pwin_q     <= pwin_d;
      gwin_q     <= gwin_d;
      err_q      <= err_d;
      rec_q      <= rec_d;
      hs_q       <= hs_d;
      hid_q      <= hid_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Score memory write port; a write pending at a reset edge is dropped
  always_ff @(posedge Clk) begin
    if (we_q && !Rst) begin
      mem[waddr_q] <= wdata_q;
    end
  end

  // Read pipeline: the latched ID is the only read address
  always_ff @(posedge Clk) begin
    rd_pipe_q[0] <= mem[id_q];
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign Busy         = busy_q;
  assign Done         = done_q;
  assign PersonalWin  = pwin_q;
  assign GlobalWinner = gwin_q;
  assign Error        = err_q;
  assign PlayerRecord = rec_q;
  assign HighScore    = hs_q;
  assign HighID       = hid_q;

endmodule

// File: tb/tb_score_tracker_multi.sv
// Bench for score_tracker_multi: two instances (best-score and cumulative),
// randomized submissions, scoreboard queues checked by a Done monitor.
module tb_score_tracker_multi;

  typedef struct {
    bit pwin;
    bit gwin;
    bit err;
    int rec;
    int hs;
    int hid;
    int acc;
    int lat;
  } exp_t;

  logic       clk;
  logic       rst  [2];
  logic       req  [2];
  logic [1:0] pid  [2];
  logic [4:0] scr  [2];
  logic       clr  [2];
  logic       busy [2];
  logic       done [2];
  logic       pwin [2];
  logic       gwin [2];
  logic       err  [2];
  logic [4:0] prec [2];
  logic [4:0] hs   [2];
  logic [1:0] hid  [2];

  int   checks;
  int   errors;
  int   cyc;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t mon_e;

  int m_rec  [2][4];
  int m_hs   [2];
  int m_hid  [2];
  int m_prec [2];

  score_tracker_multi #(.NUM_PLAYERS(4), .ID_W(2), .SCORE_W(5), .READ_LAT(2), .MODE(0)) dut_a (
    .Clk(clk), .Rst(rst[0]), .ScoreReq(req[0]), .PlayerID(pid[0]), .Score(scr[0]),
    .ClearReq(clr[0]), .Busy(busy[0]), .Done(done[0]), .PersonalWin(pwin[0]),
    .GlobalWinner(gwin[0]), .Error(err[0]), .PlayerRecord(prec[0]),
    .HighScore(hs[0]), .HighID(hid[0]));

  score_tracker_multi #(.NUM_PLAYERS(3), .ID_W(2), .SCORE_W(5), .READ_LAT(3), .MODE(1)) dut_b (
    .Clk(clk), .Rst(rst[1]), .ScoreReq(req[1]), .PlayerID(pid[1]), .Score(scr[1]),
    .ClearReq(clr[1]), .Busy(busy[1]), .Done(done[1]), .PersonalWin(pwin[1]),
    .GlobalWinner(gwin[1]), .Error(err[1]), .PlayerRecord(prec[1]),
    .HighScore(hs[1]), .HighID(hid[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int np(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int rlat(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_clear(input int d);
    for (int p = 0; p < 4; p++) m_rec[d][p] = 0;
    m_hs[d]  = 0;
    m_hid[d] = 0;
  endtask

  // Monitor: every Done pulse pops one expectation and compares
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done[d]) begin
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done dut=%0d actual=1 required=0", d);
        end else begin
          if (d == 0) mon_e = sb0.pop_front();
          else        mon_e = sb1.pop_front();
          chk($sformatf("latency_d%0d", d), cyc - mon_e.acc, mon_e.lat);
          chk($sformatf("busy_at_done_d%0d", d), int'(busy[d]), 1);
          chk($sformatf("personal_win_d%0d", d), int'(pwin[d]), int'(mon_e.pwin));
          chk($sformatf("global_win_d%0d", d), int'(gwin[d]), int'(mon_e.gwin));
          chk($sformatf("error_d%0d", d), int'(err[d]), int'(mon_e.err));
          chk($sformatf("player_record_d%0d", d), int'(prec[d]), mon_e.rec);
          chk($sformatf("high_score_d%0d", d), int'(hs[d]), mon_e.hs);
          chk($sformatf("high_id_d%0d", d), int'(hid[d]), mon_e.hid);
        end
      end
    end
  end

  // Submit one score; expected result comes from the reference rules
  task automatic submit(input int d, input int p, input int s, input int hold);
    exp_t e;
    int   old;
    int   nw;
    int   n_extra;
    bit   seen;
    e.err = (p >= np(d));
    if (e.err) begin
      e.pwin = 1'b0;
      e.gwin = 1'b0;
      e.rec  = m_prec[d];
      e.lat  = 1;
    end else begin
      old = m_rec[d][p];
      if (d == 1) nw = (old + s > 31) ? 31 : old + s;
      else        nw = s;
      e.pwin = (nw > old);
      if (e.pwin) m_rec[d][p] = nw;
      e.rec  = m_rec[d][p];
      e.gwin = (nw > m_hs[d]);
      if (e.gwin) begin
        m_hs[d]  = nw;
        m_hid[d] = p;
      end
      e.lat = rlat(d) + 4;
    end
    m_prec[d] = e.rec;
    e.hs  = m_hs[d];
    e.hid = m_hid[d];

    @(negedge clk);
    pid[d] = 2'(p);
    scr[d] = 5'(s);
    req[d] = 1'b1;
    e.acc  = cyc + 1;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);

    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done[d]) seen = 1'b1;
    end
    chk($sformatf("done_within_budget_d%0d", d), int'(seen), 1);

    n_extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (done[d]) n_extra++;
    end
    if (hold > 0) chk($sformatf("held_req_extra_done_d%0d", d), n_extra, 0);
    req[d] = 1'b0;
    @(negedge clk);
  endtask

  // Reset, check outputs cleared, then count INIT busy cycles
  task automatic do_reset(input int d);
    int cnt;
    @(negedge clk);
    rst[d] = 1'b1;
    req[d] = 1'b0;
    clr[d] = 1'b0;
    repeat (2) @(negedge clk);
    chk($sformatf("rst_busy_d%0d", d), int'(busy[d]), 0);
    chk($sformatf("rst_done_d%0d", d), int'(done[d]), 0);
    chk($sformatf("rst_pwin_d%0d", d), int'(pwin[d]), 0);
    chk($sformatf("rst_gwin_d%0d", d), int'(gwin[d]), 0);
    chk($sformatf("rst_err_d%0d", d), int'(err[d]), 0);
    chk($sformatf("rst_prec_d%0d", d), int'(prec[d]), 0);
    chk($sformatf("rst_hs_d%0d", d), int'(hs[d]), 0);
    chk($sformatf("rst_hid_d%0d", d), int'(hid[d]), 0);
    rst[d] = 1'b0;
    model_clear(d);
    m_prec[d] = 0;
    cnt = 0;
    for (int i = 0; i < np(d) + 4; i++) begin
      @(negedge clk);
      if (busy[d]) cnt++;
    end
    chk($sformatf("init_busy_cycles_d%0d", d), cnt, np(d));
    chk($sformatf("post_init_busy_d%0d", d), int'(busy[d]), 0);
  endtask

  // ClearReq and ScoreReq together in IDLE: clear wins, no submission
  task automatic clear_with_req(input int d);
    @(negedge clk);
    clr[d] = 1'b1;
    req[d] = 1'b1;
    pid[d] = 2'd0;
    scr[d] = 5'd5;
    @(negedge clk);
    clr[d] = 1'b0;
    req[d] = 1'b0;
    chk($sformatf("clear_busy_d%0d", d), int'(busy[d]), 1);
    model_clear(d);
    repeat (np(d) + 2) @(negedge clk);
    chk($sformatf("clear_idle_d%0d", d), int'(busy[d]), 0);
    chk($sformatf("clear_hs_d%0d", d), int'(hs[d]), 0);
    chk($sformatf("clear_hid_d%0d", d), int'(hid[d]), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      req[d] = 1'b0;
      clr[d] = 1'b0;
      pid[d] = 2'd0;
      scr[d] = 5'd0;
      m_prec[d] = 0;
      model_clear(d);
    end

    do_reset(0);
    do_reset(1);

    // Best-score instance: directed cases
    submit(0, 2, 9, 0);
    submit(0, 2, 7, 0);
    submit(0, 1, 9, 0);
    submit(0, 3, 12, 20);
    for (int i = 0; i < 30; i++) begin
      submit(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 0);
    end
    clear_with_req(0);
    submit(0, 0, 4, 0);
    submit(0, 0, 0, 0);

    // Reset while READ is in progress
    @(negedge clk);
    pid[0] = 2'd1;
    scr[0] = 5'd30;
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_in_read_d0", int'(busy[0]), 1);
    do_reset(0);
    for (int i = 0; i < 15; i++) begin
      submit(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 0);
    end

    // Cumulative instance with three players
    submit(1, 0, 20, 0);
    submit(1, 0, 20, 0);
    submit(1, 0, 5, 0);
    submit(1, 3, 7, 0);
    submit(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      submit(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 0);
    end
    clear_with_req(1);
    for (int i = 0; i < 10; i++) begin
      submit(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 0);
    end

    repeat (5) @(negedge clk);
    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
